// File: rtl/stopwatch_lap_core_if.sv
// Stopwatch core pin bundle: button strobes and lap read index in, display/status/lap data out.
// Latency: none, wires only.
// Backpressure: none, all signals are level/pulse with no handshake.
interface stopwatch_lap_core_if #(
    parameter int LAP_DEPTH = 8
) ();
    localparam int IW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CW = $clog2(LAP_DEPTH + 1);

    logic          start_stop_pulse;
    logic          lap_pulse;
    logic          lap_held;
    logic [IW-1:0] lap_rd_idx;
    logic [15:0]   disp_bcd;
    logic          running;
    logic          frozen;
    logic [CW-1:0] lap_count;
    logic [15:0]   lap_rd_data;
    logic          wrap;

    modport master (
        output start_stop_pulse, lap_pulse, lap_held, lap_rd_idx,
        input  disp_bcd, running, frozen, lap_count, lap_rd_data, wrap
    );

    modport slave (
        input  start_stop_pulse, lap_pulse, lap_held, lap_rd_idx,
        output disp_bcd, running, frozen, lap_count, lap_rd_data, wrap
    );
endinterface

// File: rtl/stopwatch_lap_core.sv
// BCD MM:SS stopwatch with start/pause FSM, lap freeze, long-push clear and lap history ring.
// Latency: time/status update one cycle after the causing event; lap_rd_data one cycle after lap_rd_idx.
// Backpressure: none; STOPWATCH_SAT_EN selects hold-at-59:59 instead of roll-over.
module stopwatch_lap_core #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int HOLD_CYC  = 100_000_000,
    parameter int LAP_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    stopwatch_lap_core_if.slave sw
);
    localparam int IW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CW = $clog2(LAP_DEPTH + 1);
    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_CYC);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYC - 1);
    localparam logic [IW-1:0] WR_MAX    = IW'(LAP_DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(LAP_DEPTH);
    localparam logic [15:0]   TIME_MAX  = 16'h5959;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t        state_q,      state_d;
    logic          running_q,    running_d;
    logic [PW-1:0] presc_q,      presc_d;
    logic [15:0]   time_q,       time_d;
    logic          wrap_q,       wrap_d;
    logic          frozen_q,     frozen_d;
    logic [15:0]   freeze_q,     freeze_d;
    logic [15:0]   lap_mem_q [LAP_DEPTH];
    logic [15:0]   lap_mem_d [LAP_DEPTH];
    logic [IW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [CW-1:0] lap_count_q,  lap_count_d;
    logic [15:0]   rd_data_q,    rd_data_d;
    logic [HW-1:0] hold_q,       hold_d;
    logic          armed_q,      armed_d;
    logic          sat_stop_q,   sat_stop_d;

    logic          tick;
    logic          clear;
    int            rd_a;
    logic [IW-1:0] rd_addr;

    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] n;
        n = t;
        if (t[3:0] != 4'd9) begin
            n[3:0] = t[3:0] + 4'd1;
        end else begin
            n[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                n[7:4] = t[7:4] + 4'd1;
            end else begin
                n[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    n[11:8] = t[11:8] + 4'd1;
                end else begin
                    n[11:8]  = 4'd0;
                    n[15:12] = (t[15:12] != 4'd5) ? t[15:12] + 4'd1 : 4'd0;
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        time_d      = time_q;
        wrap_d      = 1'b0;
        frozen_d    = frozen_q;
        freeze_d    = freeze_q;
        lap_mem_d   = lap_mem_q;
        wr_ptr_d    = wr_ptr_q;
        lap_count_d = lap_count_q;
        sat_stop_d  = sat_stop_q;
        tick        = 1'b0;

        // Hold counter saturates so a long press cannot wrap into a second clear.
        hold_d  = sw.lap_held ? ((hold_q != HOLD_MAX) ? hold_q + HW'(1) : hold_q) : '0;
        armed_d = sw.lap_held ? armed_q : 1'b1;
        clear   = sw.lap_held && armed_q && (hold_q == HOLD_MAX);

        if (clear) begin
            state_d     = ST_IDLE;
            presc_d     = '0;
            time_d      = '0;
            frozen_d    = 1'b0;
            wr_ptr_d    = '0;
            lap_count_d = '0;
            sat_stop_d  = 1'b0;
            armed_d     = 1'b0;
        end else begin
            if (state_q == ST_RUN && !sat_stop_q) begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    tick    = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            if (tick) begin
                if (time_q == TIME_MAX) begin
                    wrap_d = 1'b1;
`ifdef STOPWATCH_SAT_EN
                    sat_stop_d = 1'b1;
`else
                    time_d = '0;
`endif
                end else begin
                    time_d = bcd_inc(time_q);
                end
            end

            // Lap decisions use the pre-tick time and the pre-transition state.
            if (sw.lap_pulse) begin
                if (state_q == ST_RUN && !frozen_q) begin
                    frozen_d            = 1'b1;
                    freeze_d            = time_q;
                    lap_mem_d[wr_ptr_q] = time_q;
                    wr_ptr_d            = (wr_ptr_q == WR_MAX) ? '0 : wr_ptr_q + IW'(1);
                    if (lap_count_q != CNT_MAX) begin
                        lap_count_d = lap_count_q + CW'(1);
                    end
                end else begin
                    frozen_d = 1'b0;
                end
            end

            if (sw.start_stop_pulse) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_RUN;
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = ST_IDLE;
                endcase
            end
        end

        running_d = (state_d == ST_RUN);
    end

    always_comb begin
        rd_a = int'(wr_ptr_q) - 1 - int'(sw.lap_rd_idx);
        if (rd_a < 0) begin
            rd_a = rd_a + LAP_DEPTH;
        end
        rd_addr   = IW'(rd_a);
        rd_data_d = (int'(sw.lap_rd_idx) >= int'(lap_count_q)) ? 16'h0000 : lap_mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            running_q   <= 1'b0;
            presc_q     <= '0;
            time_q      <= '0;
            wrap_q      <= 1'b0;
            frozen_q    <= 1'b0;
            freeze_q    <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                lap_mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            lap_count_q <= '0;
            rd_data_q   <= '0;
            hold_q      <= '0;
            armed_q     <= 1'b1;
            sat_stop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            running_q   <= running_d;
            presc_q     <= presc_d;
            time_q      <= time_d;
            wrap_q      <= wrap_d;
            frozen_q    <= frozen_d;
            freeze_q    <= freeze_d;
            lap_mem_q   <= lap_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            lap_count_q <= lap_count_d;
            rd_data_q   <= rd_data_d;
            hold_q      <= hold_d;
            armed_q     <= armed_d;
            sat_stop_q  <= sat_stop_d;
        end
    end

    assign sw.disp_bcd    = frozen_q ? freeze_q : time_q;
    assign sw.running     = running_q;
    assign sw.frozen      = frozen_q;
    assign sw.lap_count   = lap_count_q;
    assign sw.lap_rd_data = rd_data_q;
    assign sw.wrap        = wrap_q;
endmodule
